// File: rtl/gen_frame_ctrl.sv
// Frame sequencer for the 8-bit test-data generator: header byte, then frame_len payload beats
// per frame on a valid/ready stream, with idle gaps between frames and a done pulse per run.
module gen_frame_ctrl #(
  parameter int unsigned LEN_W    = 6,
  parameter int unsigned GAP_CYC  = 2,
  parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [7:0]       num_frames,
  input  logic [7:0]       gen_data,
  output logic             gen_en,
  output logic             gen_clr_n,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic [7:0]       frame_idx
);

  localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [2:0] {StIdle, StHdr, StPay, StGap, StDone} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, beat_q, beat_d;
  logic [7:0]       frames_q, frames_d, fidx_q, fidx_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             clr_n_q, clr_n_d, done_q, done_d;
  logic             hs, beat_last, frame_last;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    frames_d   = frames_q;
    beat_d     = beat_q;
    fidx_d     = fidx_q;
    gap_d      = gap_q;
    clr_n_d    = 1'b1;
    done_d     = 1'b0;
    out_data   = 8'h00;
    out_last   = 1'b0;
    gen_en     = 1'b0;
    out_valid  = (state_q == StHdr) || (state_q == StPay);
    hs         = out_valid && out_ready;
    beat_last  = (beat_q == len_q - LEN_W'(1));
    frame_last = (fidx_q == frames_q - 8'd1);

    unique case (state_q)
      StIdle: begin
        if (start && (frame_len != '0) && (num_frames != '0)) begin
          state_d  = StHdr;
          len_d    = frame_len;
          frames_d = num_frames;
          fidx_d   = 8'd0;
          // Clear lands during the first header cycle so payload starts at 0.
          clr_n_d  = 1'b0;
        end
      end
      StHdr: begin
        out_data = HDR_BYTE;
        if (hs) begin
          state_d = StPay;
          beat_d  = '0;
        end
      end
      StPay: begin
        out_data = gen_data;
        out_last = beat_last;
        gen_en   = hs;
        if (hs) begin
          beat_d = beat_q + LEN_W'(1);
          if (beat_last) begin
            if (frame_last) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              fidx_d = fidx_q + 8'd1;
              if (GAP_CYC == 0) begin
                state_d = StHdr;
              end else begin
                state_d = StGap;
                gap_d   = '0;
              end
            end
          end
        end
      end
      StGap: begin
        if (gap_q == GapLast) state_d = StHdr;
        else gap_d = gap_q + GapW'(1);
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      len_q    <= '0;
      frames_q <= 8'd0;
      beat_q   <= '0;
      fidx_q   <= 8'd0;
      gap_q    <= '0;
      clr_n_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      frames_q <= frames_d;
      beat_q   <= beat_d;
      fidx_q   <= fidx_d;
      gap_q    <= gap_d;
      clr_n_q  <= clr_n_d;
      done_q   <= done_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign gen_clr_n = clr_n_q;
  assign frame_idx = fidx_q;

endmodule

// File: tb/tb_gen_frame_ctrl.sv
// Scoreboard bench for gen_frame_ctrl: expected beats are queued per run from a simple
// counting model; a negedge monitor pops and compares on every handshake.
module tb_gen_frame_ctrl;
  localparam int unsigned LW  = 6;
  localparam int          GAP = 2;
  localparam logic [7:0]  HDR = 8'hA5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] frame_len;
  logic [7:0]    num_frames;
  logic [7:0]    gen_data;
  logic          gen_en, gen_clr_n, out_valid, out_ready, out_last, busy, done;
  logic [7:0]    out_data, frame_idx;

  gen_frame_ctrl #(.LEN_W(LW), .GAP_CYC(GAP), .HDR_BYTE(HDR)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .frame_len (frame_len),
    .num_frames(num_frames),
    .gen_data  (gen_data),
    .gen_en    (gen_en),
    .gen_clr_n (gen_clr_n),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .frame_idx (frame_idx)
  );

  always #5 clk = ~clk;

  // Test-data generator: counts 0..31 and wraps, synchronous active-low clear.
  logic [7:0] gen_q;
  always @(posedge clk) begin
    if (!rst || !gen_clr_n) gen_q <= 8'd0;
    else if (gen_en) gen_q <= (gen_q == 8'd31) ? 8'd0 : gen_q + 8'd1;
  end
  assign gen_data = gen_q;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic [7:0] fidx;
    logic       hdr;
    logic       fin;
    int         gap;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  int   cyc = 0, idle = 0, last_fin_cyc = 0;
  int   en_cnt = 0, clr_cnt = 0, done_cnt = 0;
  bit   rand_ready = 0;
  logic prev_stall = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops one expected beat per handshake.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst) begin
      prev_stall = 1'b0;
      idle = 0;
    end else begin
      if (gen_en) en_cnt++;
      if (!gen_clr_n) begin
        clr_cnt++;
        chk("clr_in_first_hdr", {out_valid, out_data}, {1'b1, HDR});
      end
      if (done) begin
        done_cnt++;
        chk("done_latency", cyc - last_fin_cyc, 1);
      end
      if (prev_stall)
        chk("stall_hold", {out_valid, out_data, out_last}, {1'b1, prev_data, prev_last});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h with no beat expected", out_data);
        end else begin
          e = q.pop_front();
          chk("data", out_data, e.data);
          chk("last", out_last, e.last);
          chk("frame_idx", frame_idx, e.fidx);
          chk("gen_en_on_hs", gen_en, !e.hdr);
          if (e.gap >= 0) chk("gap_len", idle, e.gap);
          if (e.fin) last_fin_cyc = cyc;
        end
        idle = 0;
      end else begin
        if (gen_en) chk("gen_en_no_hs", gen_en, 1'b0);
        if (!out_valid) idle++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic build(input int len, input int frames);
    int v = 0;
    for (int f = 0; f < frames; f++) begin
      q.push_back('{HDR, 1'b0, 8'(f), 1'b1, 1'b0, (f == 0) ? -1 : GAP});
      for (int i = 0; i < len; i++) begin
        q.push_back('{8'(v), i == len - 1, 8'(f), 1'b0,
                      (f == frames - 1) && (i == len - 1), -1});
        v = (v + 1) % 32;
      end
    end
  endtask

  task automatic issue_start(input int len, input int frames);
    @(posedge clk);
    #1;
    start      = 1'b1;
    frame_len  = LW'(len);
    num_frames = 8'(frames);
    @(posedge clk);
    #1;
    start      = 1'b0;
    frame_len  = LW'($urandom);
    num_frames = 8'($urandom);
  endtask

  task automatic run(input int len, input int frames, input bit rr, input bit mid);
    en_cnt = 0; clr_cnt = 0; done_cnt = 0;
    rand_ready = rr;
    build(len, frames);
    issue_start(len, frames);
    @(negedge clk);
    chk("start_latency_valid", out_valid, 1'b1);
    chk("busy_in_run", busy, 1'b1);
    if (mid) begin
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1; frame_len = LW'(7); num_frames = 8'd5;
      @(posedge clk);
      #1 start = 1'b0;
    end
    for (int i = 0; i < 3000 && done_cnt == 0; i++) @(posedge clk);
    if (done_cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: got no done expected done (len %0d frames %0d)", len, frames);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("busy_after", busy, 1'b0);
    chk("done_after", done, 1'b0);
    chk("beats_left", q.size(), 0);
    chk("gen_en_count", en_cnt, len * frames);
    chk("clr_count", clr_cnt, 1);
    chk("done_count", done_cnt, 1);
    chk("frame_idx_hold", frame_idx, frames - 1);
    q.delete();
  endtask

  task automatic bad_start(input int len, input int frames);
    issue_start(len, frames);
    repeat (4) begin
      @(negedge clk);
      chk("bad_start_busy", busy, 1'b0);
      chk("bad_start_valid", out_valid, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; frame_len = '0; num_frames = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_gen_en", gen_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_clr_n", gen_clr_n, 1'b1);
    chk("rst_frame_idx", frame_idx, 8'd0);

    run(4, 1, 1'b0, 1'b0);
    run(3, 3, 1'b0, 1'b1);
    run(40, 1, 1'b0, 1'b0);
    run(5, 2, 1'b1, 1'b1);
    bad_start(0, 3);
    bad_start(4, 0);

    // Abort during payload beat 2 of a 6-beat frame.
    en_cnt = 0; clr_cnt = 0; done_cnt = 0;
    rand_ready = 1'b0;
    build(6, 1);
    issue_start(6, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_valid", out_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_frame_idx", frame_idx, 8'd0);
    q.delete();
    repeat (4) @(negedge clk);
    chk("abort_no_done", done_cnt, 0);
    run(6, 1, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++)
      run(int'($urandom_range(1, 12)), int'($urandom_range(1, 3)), 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
